data_bus_unit: RTL and testbench

//  Data-side slave of the single-cycle core. Consumes the core's daddr/ddata_w/d_rw and returns ddata_r in the same cycle.

---
 rtl/data_bus_pkg.sv | 32 +++
 rtl/data_bus_unit_timer.sv | 76 +++++++
 rtl/data_bus_unit.sv | 118 +++++++++++
 tb/tb_data_bus_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared constants and types for the data-side bus slave: IO register map,
// timer control bit positions and the packed timer control word.
package data_bus_pkg;

    localparam logic [31:0] IO_BASE      = 32'h0000_1000;
    localparam logic [31:0] OFS_GPIO_OUT = 32'h0000_0000;
    localparam logic [31:0] OFS_GPIO_IN  = 32'h0000_0004;
    localparam logic [31:0] OFS_TMR_CNT  = 32'h0000_0008;
    localparam logic [31:0] OFS_TMR_CMP  = 32'h0000_000C;
    localparam logic [31:0] OFS_TMR_CTRL = 32'h0000_0010;
    localparam logic [31:0] OFS_TMR_STAT = 32'h0000_0014;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT     = 2;
    localparam int STAT_MATCH_BIT      = 0;

    typedef struct packed {
        logic irq_en;
        logic autoreload;
        logic en;
    } tmr_ctrl_t;

    function automatic tmr_ctrl_t ctrlFromBits(input logic [2:0] bits);
        tmr_ctrl_t c;
        c.en         = bits[CTRL_EN_BIT];
        c.autoreload = bits[CTRL_AUTORELOAD_BIT];
        c.irq_en     = bits[CTRL_IRQ_EN_BIT];
        return c;
    endfunction

endpackage

// File: rtl/data_bus_unit_timer.sv
// 32-bit free-running / auto-reload timer with compare, sticky MATCH flag
// and level interrupt; driven by pre-decoded write strobes from the bus.
module bus_timer
    import data_bus_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         wrCnt_i,
    input  logic         wrCmp_i,
    input  logic         wrCtrl_i,
    input  logic         wrStat_i,
    input  logic [N-1:0] wdata_i,
    output logic [N-1:0] cnt_o,
    output logic [N-1:0] cmp_o,
    output tmr_ctrl_t    ctrl_o,
    output logic         match_o,
    output logic         irq_o
);

    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] cmp_q, cmp_d;
    tmr_ctrl_t    ctrl_q, ctrl_d;
    logic         match_q, match_d;
    logic         hit;

    // Compare always uses the registered CMP, so a same-cycle CMP write
    // only affects the following cycle.
    assign hit = ctrl_q.en && (cnt_q == cmp_q);

    always_comb begin
        cnt_d = cnt_q;
        if (wrCnt_i) begin
            cnt_d = wdata_i;
        end else if (ctrl_q.en) begin
            cnt_d = (ctrl_q.autoreload && hit) ? '0 : cnt_q + N'(1);
        end
    end

    always_comb begin
        cmp_d  = wrCmp_i ? wdata_i : cmp_q;
        ctrl_d = wrCtrl_i ? ctrlFromBits(wdata_i[2:0]) : ctrl_q;
    end

    // A hardware match wins over a software clear in the same cycle.
    always_comb begin
        match_d = match_q;
        if (hit) begin
            match_d = 1'b1;
        end else if (wrStat_i && wdata_i[STAT_MATCH_BIT]) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q   <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cmp_o   = cmp_q;
    assign ctrl_o  = ctrl_q;
    assign match_o = match_q;
    assign irq_o   = match_q & ctrl_q.irq_en;

endmodule

// File: rtl/data_bus_unit.sv
// Data-side slave of the single-cycle core: word RAM, GPIO with input
// synchroniser and a compare timer, all read combinationally from daddr.
module data_bus_unit
    import data_bus_pkg::*;
#(
    parameter int N         = 32,
    parameter int RAM_WORDS = 256,
    parameter int GPIO_W    = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [N-1:0]      daddr_i,
    input  logic [N-1:0]      ddata_w_i,
    input  logic              d_rw_i,
    output logic [N-1:0]      ddata_r_o,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic              irq_o
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [N-1:0] ADDR_GPIO_OUT = N'(IO_BASE + OFS_GPIO_OUT);
    localparam logic [N-1:0] ADDR_GPIO_IN  = N'(IO_BASE + OFS_GPIO_IN);
    localparam logic [N-1:0] ADDR_TMR_CNT  = N'(IO_BASE + OFS_TMR_CNT);
    localparam logic [N-1:0] ADDR_TMR_CMP  = N'(IO_BASE + OFS_TMR_CMP);
    localparam logic [N-1:0] ADDR_TMR_CTRL = N'(IO_BASE + OFS_TMR_CTRL);
    localparam logic [N-1:0] ADDR_TMR_STAT = N'(IO_BASE + OFS_TMR_STAT);

    logic [AW-1:0]     ramIdx;
    logic              isRam;
    logic              selGpioOut, selGpioIn, selCnt, selCmp, selCtrl, selStat;
    logic [N-1:0]      ram_q [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [N-1:0]      tmrCnt, tmrCmp;
    tmr_ctrl_t         tmrCtrl;
    logic              tmrMatch;
    logic [N-1:0]      rdata;
    logic              unusedAddrBits;

    // Byte offset bits are ignored everywhere; the whole upper address must
    // match so aliases above the map read as unmapped.
    assign unusedAddrBits = ^daddr_i[1:0];
    assign ramIdx     = daddr_i[AW+1:2];
    assign isRam      = (daddr_i[N-1:AW+2] == '0);
    assign selGpioOut = (daddr_i[N-1:2] == ADDR_GPIO_OUT[N-1:2]);
    assign selGpioIn  = (daddr_i[N-1:2] == ADDR_GPIO_IN[N-1:2]);
    assign selCnt     = (daddr_i[N-1:2] == ADDR_TMR_CNT[N-1:2]);
    assign selCmp     = (daddr_i[N-1:2] == ADDR_TMR_CMP[N-1:2]);
    assign selCtrl    = (daddr_i[N-1:2] == ADDR_TMR_CTRL[N-1:2]);
    assign selStat    = (daddr_i[N-1:2] == ADDR_TMR_STAT[N-1:2]);

    always_ff @(posedge CLK) begin
        if (d_rw_i && isRam) begin
            ram_q[ramIdx] <= ddata_w_i;
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (d_rw_i && selGpioOut) begin
            gpio_out_d = ddata_w_i[GPIO_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in_i;
            sync2_q    <= sync1_q;
        end
    end

    bus_timer #(
        .N (N)
    ) u_timer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .wrCnt_i  (d_rw_i && selCnt),
        .wrCmp_i  (d_rw_i && selCmp),
        .wrCtrl_i (d_rw_i && selCtrl),
        .wrStat_i (d_rw_i && selStat),
        .wdata_i  (ddata_w_i),
        .cnt_o    (tmrCnt),
        .cmp_o    (tmrCmp),
        .ctrl_o   (tmrCtrl),
        .match_o  (tmrMatch),
        .irq_o    (irq_o)
    );

    always_comb begin
        rdata = '0;
        if (isRam) begin
            rdata = ram_q[ramIdx];
        end else if (selGpioOut) begin
            rdata[GPIO_W-1:0] = gpio_out_q;
        end else if (selGpioIn) begin
            rdata[GPIO_W-1:0] = sync2_q;
        end else if (selCnt) begin
            rdata = tmrCnt;
        end else if (selCmp) begin
            rdata = tmrCmp;
        end else if (selCtrl) begin
            rdata[2:0] = tmrCtrl;
        end else if (selStat) begin
            rdata[STAT_MATCH_BIT] = tmrMatch;
        end
    end

    assign ddata_r_o  = rdata;
    assign gpio_out_o = gpio_out_q;

endmodule

// File: tb/tb_data_bus_unit.sv
// Self-checking bench for data_bus_unit: directed vector table, hand-written
// timer/reset sequences, then random traffic against a reference model.
module tb_data_bus_unit;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] daddr;
   logic [31:0] ddataW;
   logic        dRw;
   logic [31:0] ddataR;
   logic [7:0]  gpioIn;
   logic [7:0]  gpioOut;
   logic        irq;

   int compared   = 0;
   int mismatched = 0;

   // 100 MHz-style free-running clock, rising edges at 5, 15, 25 ...
   always #5 CLK = ~CLK;

   data_bus_unit #(
      .N         (32),
      .RAM_WORDS (256),
      .GPIO_W    (8)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .daddr_i    (daddr),
      .ddata_w_i  (ddataW),
      .d_rw_i     (dRw),
      .ddata_r_o  (ddataR),
      .gpio_in_i  (gpioIn),
      .gpio_out_o (gpioOut),
      .irq_o      (irq)
   );

   // Reference model: register file as plain variables, RAM as a sparse map,
   // GPIO input visibility as a two-entry history of sampled values.
   logic [31:0] mRam [int unsigned];
   logic [7:0]  mGpioOut;
   logic [31:0] mCnt;
   logic [31:0] mCmp;
   logic [2:0]  mCtrl;
   logic        mMatch;
   logic [7:0]  mSync [$];

   function automatic void modelReset();
      mGpioOut = 8'h00;
      mCnt     = 32'h0;
      mCmp     = 32'hFFFF_FFFF;
      mCtrl    = 3'b000;
      mMatch   = 1'b0;
      mSync.delete();
      mSync.push_back(8'h00);
      mSync.push_back(8'h00);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr, output bit known);
      logic [31:0] a;
      a = addr & 32'hFFFF_FFFC;
      known = 1'b1;
      if (a < 32'd1024) begin
         if (mRam.exists(a >> 2)) return mRam[a >> 2];
         known = 1'b0;
         return 32'h0;
      end
      case (a)
         32'h1000: return {24'h0, mGpioOut};
         32'h1004: return {24'h0, mSync[0]};
         32'h1008: return mCnt;
         32'h100C: return mCmp;
         32'h1010: return {29'h0, mCtrl};
         32'h1014: return {31'h0, mMatch};
         default:  return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock edge using the bus inputs held across it.
   function automatic void modelStep();
      logic [31:0] a;
      logic [31:0] nextCnt;
      bit          hit;
      a = daddr & 32'hFFFF_FFFC;
      hit = mCtrl[0] && (mCnt == mCmp);
      nextCnt = mCnt;
      if (mCtrl[0]) nextCnt = (mCtrl[1] && hit) ? 32'h0 : mCnt + 32'd1;
      if (hit) mMatch = 1'b1;
      else if (dRw && a == 32'h1014 && ddataW[0]) mMatch = 1'b0;
      mSync.push_back(gpioIn);
      void'(mSync.pop_front());
      if (dRw) begin
         if (a < 32'd1024) mRam[a >> 2] = ddataW;
         else begin
            case (a)
               32'h1000: mGpioOut = ddataW[7:0];
               32'h1008: nextCnt  = ddataW;
               32'h100C: mCmp     = ddataW;
               32'h1010: mCtrl    = ddataW[2:0];
               default: ;
            endcase
         end
      end
      mCnt = nextCnt;
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rw;
      logic [7:0]  gpio;
      bit          chk;
      logic [31:0] expRd;
      logic [7:0]  expGpio;
   } vec_t;

   vec_t vecs [$];

   function automatic void addVec(input logic [31:0] a, input logic [31:0] w, input logic rw,
                                  input logic [7:0] g, input bit chk, input logic [31:0] e,
                                  input logic [7:0] eg);
      vec_t v;
      v.addr = a; v.wdata = w; v.rw = rw; v.gpio = g;
      v.chk = chk; v.expRd = e; v.expGpio = eg;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; the read is sampled 1 ns later.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic rw);
      @(negedge CLK);
      daddr  = addr;
      ddataW = wdata;
      dRw    = rw;
      #1;
   endtask

   task automatic stepEdge();
      @(posedge CLK);
      modelStep();
      #1;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      applyStimulus(addr, 32'h0, 1'b0);
      checkOutput(name, ddataR, exp);
      stepEdge();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(addr, data, 1'b1);
      stepEdge();
   endtask

   initial begin
      logic [31:0] exp;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          known;
      logic [31:0] unmapped [4];

      RESET_N = 1'b0;
      daddr   = 32'h0;
      ddataW  = 32'h0;
      dRw     = 1'b0;
      gpioIn  = 8'h00;
      modelReset();
      unmapped[0] = 32'h0000_0400;
      unmapped[1] = 32'h0000_1018;
      unmapped[2] = 32'h0000_2000;
      unmapped[3] = 32'hFFFF_1000;

      // Directed vectors: RAM, GPIO, register reset values, unmapped space.
      addVec(32'h0004, 32'hDEAD_BEEF, 1, 8'h00, 0, 32'h0,         8'h00);
      addVec(32'h0004, 32'h0,         0, 8'h00, 1, 32'hDEAD_BEEF, 8'h00);
      addVec(32'h0004, 32'h1234_5678, 1, 8'h00, 1, 32'hDEAD_BEEF, 8'h00);
      addVec(32'h0004, 32'h0,         0, 8'h00, 1, 32'h1234_5678, 8'h00);
      addVec(32'h1000, 32'hFFFF_FF5A, 1, 8'h00, 1, 32'h0,         8'h5A);
      addVec(32'h1000, 32'h0,         0, 8'h3C, 1, 32'h0000_005A, 8'h5A);
      addVec(32'h1004, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h1004, 32'h0,         0, 8'h3C, 1, 32'h0000_003C, 8'h5A);
      addVec(32'h1010, 32'hFFFF_FFF8, 1, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h1010, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h100C, 32'h0,         0, 8'h3C, 1, 32'hFFFF_FFFF, 8'h5A);
      addVec(32'h1014, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h1008, 32'h0000_0010, 1, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h1008, 32'h0,         0, 8'h3C, 1, 32'h0000_0010, 8'h5A);
      addVec(32'h1008, 32'h0,         0, 8'h3C, 1, 32'h0000_0010, 8'h5A);
      addVec(32'h2000, 32'hCAFE_F00D, 1, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h2000, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h0404, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);
      addVec(32'h0007, 32'h0,         0, 8'h3C, 1, 32'h1234_5678, 8'h5A);
      addVec(32'h1018, 32'h0,         0, 8'h3C, 1, 32'h0,         8'h5A);

      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset gpio_out", {24'h0, gpioOut}, 32'h0);
      checkOutput("reset irq", {31'h0, irq}, 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         gpioIn = vecs[i].gpio;
         applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rw);
         if (vecs[i].chk) checkOutput($sformatf("vec%0d rd", i), ddataR, vecs[i].expRd);
         stepEdge();
         checkOutput($sformatf("vec%0d gpio_out", i), {24'h0, gpioOut}, {24'h0, vecs[i].expGpio});
         checkOutput($sformatf("vec%0d irq", i), {31'h0, irq}, 32'h0);
      end

      // Auto-reload at CMP=5 with interrupt, then software clear.
      wr(32'h100C, 32'd5);
      wr(32'h1008, 32'd0);
      wr(32'h1010, 32'd7);
      for (int i = 0; i <= 5; i++) begin
         applyStimulus(32'h1008, 32'h0, 1'b0);
         checkOutput($sformatf("reload cnt%0d", i), ddataR, i);
         stepEdge();
         checkOutput($sformatf("reload irq%0d", i), {31'h0, irq}, (i == 5) ? 32'h1 : 32'h0);
      end
      rd(32'h1008, 32'h0, "reload wrap cnt");
      rd(32'h1014, 32'h1, "reload match");
      wr(32'h1014, 32'h1);
      checkOutput("w1c irq", {31'h0, irq}, 32'h0);
      rd(32'h1014, 32'h0, "w1c match");
      wr(32'h1010, 32'h0);

      // Match on the same edge as a W1C: the match must survive.
      wr(32'h1008, 32'd4);
      wr(32'h1010, 32'd1);
      rd(32'h1008, 32'd4, "collide cnt");
      wr(32'h1014, 32'h1);
      checkOutput("collide irq off", {31'h0, irq}, 32'h0);
      rd(32'h1014, 32'h1, "collide match kept");
      wr(32'h1014, 32'h1);
      rd(32'h1014, 32'h0, "collide later clear");
      wr(32'h1010, 32'h0);

      // Free-running wrap through 0xFFFF_FFFF.
      wr(32'h1008, 32'hFFFF_FFFE);
      wr(32'h1010, 32'd1);
      rd(32'h1008, 32'hFFFF_FFFE, "wrap cnt0");
      rd(32'h1008, 32'hFFFF_FFFF, "wrap cnt1");
      rd(32'h1008, 32'h0000_0000, "wrap cnt2");

      // Old CMP used on the write cycle; then reset lands mid-count with MATCH set.
      wr(32'h100C, 32'd3);
      wr(32'h1010, 32'd5);
      rd(32'h1008, 32'd3, "pre-reset cnt");
      checkOutput("pre-reset irq", {31'h0, irq}, 32'h1);
      rd(32'h1014, 32'h1, "pre-reset match");
      #2;
      RESET_N = 1'b0;
      dRw     = 1'b0;
      daddr   = 32'h1008;
      modelReset();
      #1;
      checkOutput("async rst gpio_out", {24'h0, gpioOut}, 32'h0);
      checkOutput("async rst irq", {31'h0, irq}, 32'h0);
      checkOutput("async rst cnt", ddataR, 32'h0);
      daddr = 32'h1014;
      #1;
      checkOutput("async rst match", ddataR, 32'h0);
      daddr = 32'h100C;
      #1;
      checkOutput("async rst cmp", ddataR, 32'hFFFF_FFFF);
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      wr(32'h2000, 32'h5555_AAAA);
      rd(32'h2000, 32'h0, "unmapped after reset");
      rd(32'h0004, 32'h1234_5678, "ram kept over reset");
      rd(32'h1000, 32'h0, "gpio_out after reset");

      // Random traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) gpioIn = 8'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2:    addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            3:          addr = 32'h3FC + 32'($urandom_range(0, 3));
            4, 5, 6, 7, 8:
                        addr = 32'h1000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
            default:    addr = unmapped[$urandom_range(0, 3)];
         endcase
         case (addr & 32'hFFFF_FFFC)
            32'h1008, 32'h100C: wdata = 32'($urandom_range(0, 12));
            32'h1010:           wdata = 32'($urandom_range(0, 7));
            32'h1014:           wdata = 32'($urandom_range(0, 1));
            default:            wdata = $urandom;
         endcase
         applyStimulus(addr, wdata, 1'($urandom_range(0, 1)));
         exp = modelRead(addr, known);
         if (known) checkOutput($sformatf("rand rd @%h", addr), ddataR, exp);
         stepEdge();
         checkOutput("rand gpio_out", {24'h0, gpioOut}, {24'h0, mGpioOut});
         checkOutput("rand irq", {31'h0, irq}, {31'h0, mMatch & mCtrl[2]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
